bit_serial_deser: RTL and testbench

//  Downstream stage of bit_serial_mul. Collects the serial product stream y (LSB-first)

---
 rtl/bit_serial_pkg.sv | 16 +
 rtl/bit_serial_hold_reg.sv | 56 +++++
 rtl/bit_serial_deser.sv | 118 +++++++++++
 tb/tb_bit_serial_deser.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bit_serial_pkg.sv
// Types and helpers shared by the bit-serial multiplier datapath
// (x serializer and product deserializer).
package bit_serial_pkg;

   // Deserializer frame state: waiting for frame_start, or gathering bits.
   typedef enum logic {
      DS_IDLE,
      DS_COLLECT
   } deser_state_t;

   // Full product width for a W-bit multiplier.
   function automatic int prod_width(input int w);
      return 2 * w;
   endfunction

endpackage

// File: rtl/bit_serial_hold_reg.sv
// One-entry valid/ready holding register for assembled products.
// A new word is accepted when the register is empty or being drained in the
// same cycle; otherwise the word is dropped and the sticky overrun flag is set.
module bit_serial_hold_reg #(
   parameter int PW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [PW-1:0] load_data,
   input  logic          ready,
   output logic          valid,
   output logic [PW-1:0] data,
   output logic          overrun
);

   logic          valid_q, valid_d;
   logic [PW-1:0] data_q, data_d;
   logic          overrun_q, overrun_d;

   // Next-state: drain on handshake, then load or drop an arriving word.
   always_comb begin
      valid_d   = valid_q;
      data_d    = data_q;
      overrun_d = overrun_q;
      if (valid_q && ready) begin
         valid_d = 1'b0;
      end
      if (load) begin
         if (!valid_q || ready) begin
            data_d  = load_data;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         data_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         data_q    <= data_d;
         overrun_q <= overrun_d;
      end
   end

   assign valid   = valid_q;
   assign data    = data_q;
   assign overrun = overrun_q;

endmodule

// File: rtl/bit_serial_deser.sv
// Serial-to-parallel collector for the LSB-first product stream of
// bit_serial_mul. Frames are aligned by frame_start; the completed word is
// handed to a one-entry holding register on the edge that samples its last bit.
module bit_serial_deser
   import bit_serial_pkg::*;
#(
   parameter int W         = 16,
   parameter int FRAME_LEN = 2 * W - 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_start,
   input  logic                  y_bit,
   output logic                  prod_valid,
   input  logic                  prod_ready,
   output logic [2*W-1:0]        prod,
   output logic                  overrun,
   output logic                  frame_err
);

   localparam int PW    = prod_width(W);
   localparam int CNT_W = $clog2(FRAME_LEN + 1);
   // Bits held before the last one arrives; the last bit goes straight to the word.
   localparam int SH_W  = (FRAME_LEN > 1) ? FRAME_LEN - 1 : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

   generate
      if (FRAME_LEN < 1 || FRAME_LEN > 2 * W) begin : g_bad_frame_len
         $error("bit_serial_deser: FRAME_LEN must be in 1..2*W");
      end
   endgenerate

   deser_state_t     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SH_W-1:0]  shift_q, shift_d;
   logic             err_q, err_d;
   logic             complete;
   logic [PW-1:0]    word;

   // Assembled word: held bits, the live bit at FRAME_LEN-1, zeros above.
   generate
      for (genvar gi = 0; gi < PW; gi++) begin : g_word
         if (gi < FRAME_LEN - 1) begin : g_held
            assign word[gi] = shift_q[gi];
         end else if (gi == FRAME_LEN - 1) begin : g_live
            assign word[gi] = y_bit;
         end else begin : g_zero
            assign word[gi] = 1'b0;
         end
      end
   endgenerate

   // Frame FSM: frame_start always opens a new frame (flagging an abandoned one).
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      err_d    = 1'b0;
      complete = 1'b0;
      if (frame_start) begin
         err_d      = (state_q == DS_COLLECT);
         shift_d    = '0;
         shift_d[0] = y_bit;
         if (FRAME_LEN == 1) begin
            complete = 1'b1;
            state_d  = DS_IDLE;
            cnt_d    = '0;
         end else begin
            state_d = DS_COLLECT;
            cnt_d   = CNT_W'(1);
         end
      end else if (state_q == DS_COLLECT) begin
         if (cnt_q == LAST_IDX) begin
            complete = 1'b1;
            state_d  = DS_IDLE;
            cnt_d    = '0;
         end else begin
            for (int i = 0; i < SH_W; i++) begin
               if (cnt_q == CNT_W'(i)) begin
                  shift_d[i] = y_bit;
               end
            end
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // FSM, counter, shift and error-pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DS_IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         err_q   <= err_d;
      end
   end

   assign frame_err = err_q;

   bit_serial_hold_reg #(
      .PW(PW)
   ) u_hold (
      .clk       (clk),
      .rst       (rst),
      .load      (complete),
      .load_data (word),
      .ready     (prod_ready),
      .valid     (prod_valid),
      .data      (prod),
      .overrun   (overrun)
   );

endmodule

// File: tb/tb_bit_serial_deser.sv
// Randomized bench for bit_serial_deser (W=16, FRAME_LEN=31) with a queue-based
// reference model of frame assembly and the one-entry output register.
module tb_bit_serial_deser;

   localparam int W         = 16;
   localparam int FRAME_LEN = 31;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          frame_start = 1'b0;
   logic          y_bit = 1'b0;
   logic          prod_ready = 1'b0;
   logic          prod_valid;
   logic [31:0]   prod;
   logic          overrun;
   logic          frame_err;

   int n_checks = 0;
   int n_pass   = 0;
   string phase = "init";

   // Reference model state
   bit          q[$];
   bit          exp_valid   = 1'b0;
   bit          exp_overrun = 1'b0;
   bit          exp_err     = 1'b0;
   logic [31:0] exp_prod    = '0;

   bit_serial_deser #(
      .W(W),
      .FRAME_LEN(FRAME_LEN)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .y_bit       (y_bit),
      .prod_valid  (prod_valid),
      .prod_ready  (prod_ready),
      .prod        (prod),
      .overrun     (overrun),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
      end
   endtask

   // Apply one edge's inputs to the model.
   task automatic model_step(input bit fs, input bit yb, input bit rdy, input bit r);
      bit          err;
      bit          done;
      bit          nv;
      logic [31:0] w;
      err  = 1'b0;
      done = 1'b0;
      w    = '0;
      if (r) begin
         q.delete();
         exp_valid   = 1'b0;
         exp_overrun = 1'b0;
         exp_err     = 1'b0;
         exp_prod    = '0;
         return;
      end
      if (fs) begin
         if (q.size() > 0) err = 1'b1;
         q.delete();
      end
      if (fs || q.size() > 0) q.push_back(yb);
      if (q.size() == FRAME_LEN) begin
         for (int i = 0; i < FRAME_LEN; i++) w = w | (32'(q[i]) << i);
         q.delete();
         done = 1'b1;
      end
      nv = exp_valid;
      if (exp_valid && rdy) nv = 1'b0;
      if (done) begin
         if (!exp_valid || rdy) begin
            exp_prod = w;
            nv       = 1'b1;
         end else begin
            exp_overrun = 1'b1;
         end
      end
      exp_valid = nv;
      exp_err   = err;
   endtask

   task automatic cycle(input bit fs, input bit yb, input bit rdy);
      frame_start = fs;
      y_bit       = yb;
      prod_ready  = rdy;
      @(posedge clk);
      model_step(fs, yb, rdy, rst);
      #1;
      chk({phase, "/valid"},   32'(prod_valid), 32'(exp_valid));
      chk({phase, "/prod"},    prod,            exp_prod);
      chk({phase, "/overrun"}, 32'(overrun),    32'(exp_overrun));
      chk({phase, "/err"},     32'(frame_err),  32'(exp_err));
   endtask

   function automatic bit pick_ready(input int mode, input int i, input int last);
      case (mode)
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return ($urandom_range(0, 3) != 0);
         default: return (i == last);
      endcase
   endfunction

   // Send bits [first, nbits) of val; frame_start accompanies bit 0.
   task automatic send_frame(input logic [31:0] val, input int first, input int nbits,
                             input int rdy_mode);
      for (int i = first; i < nbits; i++) begin
         cycle(i == 0, val[i], pick_ready(rdy_mode, i, nbits - 1));
      end
   endtask

   task automatic idle(input int n, input int rdy_mode);
      for (int i = 0; i < n; i++) begin
         cycle(1'b0, 1'($urandom_range(0, 1)), pick_ready(rdy_mode, i, n - 1));
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle(1'b0, 1'b1, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      int a;
      int x;

      phase = "reset";
      do_reset();
      chk("reset_valid", 32'(prod_valid), 32'd0);
      chk("reset_prod", prod, 32'd0);

      phase = "t1_basic";
      send_frame(32'd1000000, 0, FRAME_LEN, 1);
      chk("t1_valid", 32'(prod_valid), 32'd1);
      chk("t1_prod", prod, 32'd1000000);
      idle(1, 1);
      chk("t1_valid_drop", 32'(prod_valid), 32'd0);

      phase = "t2_backpressure";
      do_reset();
      send_frame(32'd15, 0, FRAME_LEN, 0);
      send_frame(32'd63, 0, FRAME_LEN, 0);
      chk("t2_prod", prod, 32'd15);
      chk("t2_overrun", 32'(overrun), 32'd1);
      idle(1, 1);
      chk("t2_valid_drop", 32'(prod_valid), 32'd0);
      chk("t2_overrun_sticky", 32'(overrun), 32'd1);

      phase = "t3_restart";
      do_reset();
      send_frame(32'h7fff_ffff, 0, 10, 1);
      send_frame(32'd144, 0, 1, 1);
      chk("t3_err", 32'(frame_err), 32'd1);
      chk("t3_no_prod", 32'(prod_valid), 32'd0);
      send_frame(32'd144, 1, FRAME_LEN, 1);
      chk("t3_prod", prod, 32'd144);
      chk("t3_err_clear", 32'(frame_err), 32'd0);

      phase = "t4_coincide";
      do_reset();
      send_frame(32'd15, 0, FRAME_LEN, 0);
      send_frame(32'd36, 0, FRAME_LEN, 3);
      chk("t4_prod", prod, 32'd36);
      chk("t4_valid", 32'(prod_valid), 32'd1);
      chk("t4_overrun", 32'(overrun), 32'd0);

      phase = "t5_reset_mid";
      do_reset();
      send_frame(32'd15, 0, FRAME_LEN, 0);
      send_frame(32'h0055_aa55, 0, 20, 0);
      do_reset();
      chk("t5_valid", 32'(prod_valid), 32'd0);
      chk("t5_prod", prod, 32'd0);
      chk("t5_overrun", 32'(overrun), 32'd0);
      send_frame(32'd18, 0, FRAME_LEN, 1);
      chk("t5_prod18", prod, 32'd18);
      chk("t5_err", 32'(frame_err), 32'd0);

      phase = "t6_keepup";
      do_reset();
      for (int f = 0; f < 256; f++) begin
         a = int'($urandom_range(0, 1024));
         x = int'($urandom_range(0, 1024));
         send_frame(32'(a * x), 0, FRAME_LEN, 1);
         chk("t6_keepup_prod", prod, 32'(a * x));
      end
      chk("t6_keepup_overrun", 32'(overrun), 32'd0);

      phase = "t6_random";
      for (int f = 0; f < 1024; f++) begin
         a = int'($urandom_range(0, 1024));
         x = int'($urandom_range(0, 1024));
         if ($urandom_range(0, 31) == 0) begin
            send_frame(32'($urandom), 0, int'($urandom_range(1, FRAME_LEN - 1)), 2);
         end
         send_frame(32'(a * x), 0, FRAME_LEN, 2);
         if ($urandom_range(0, 15) == 0) idle(int'($urandom_range(1, 4)), 2);
      end
      idle(2, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
